// File: rtl/vec_alu_seq.sv
// Vector ALU sequencer: walks vl elements through an external scalar ALU, one element per cycle.
// Latency: read at acceptance+1+i, write at acceptance+3+i, done at acceptance+vl+3 (vl=0: acceptance+1).
// Backpressure: issue_ready is low from acceptance until the cycle after done; no element-level stalls.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   issue_valid/issue_ready       instruction handshake
//   issue_alu_sel, issue_vl       ALU opcode (passed through), vector length (saturated to 32)
//   issue_vs1/vs2/vd              source A, source B, destination register numbers
//   issue_scalar_en/issue_scalar  broadcast scalar as source B
//   rd_en, rd_vreg_a/b, rd_idx    register file read request; rd_data_a/b arrive one cycle later
//   alu_srcA/B, alu_sel           operands to the combinational ALU; alu_result comes back
//   wr_en, wr_vreg, wr_idx, wr_data  register file write port
//   busy, done                    instruction in progress, one-cycle completion pulse
module vec_alu_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [3:0]  issue_alu_sel,
   input  logic [5:0]  issue_vl,
   input  logic [4:0]  issue_vs1,
   input  logic [4:0]  issue_vs2,
   input  logic [4:0]  issue_vd,
   input  logic        issue_scalar_en,
   input  logic [31:0] issue_scalar,
   output logic        rd_en,
   output logic [4:0]  rd_vreg_a,
   output logic [4:0]  rd_vreg_b,
   output logic [4:0]  rd_idx,
   input  logic [31:0] rd_data_a,
   input  logic [31:0] rd_data_b,
   output logic [31:0] alu_srcA,
   output logic [31:0] alu_srcB,
   output logic [3:0]  alu_sel,
   input  logic [31:0] alu_result,
   output logic        wr_en,
   output logic [4:0]  wr_vreg,
   output logic [4:0]  wr_idx,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state;

   // Instruction fields captured at acceptance; the issue bus is ignored afterwards.
   logic [3:0]  sel_q;
   logic [5:0]  vl_q;
   logic [4:0]  vs1_q;
   logic [4:0]  vs2_q;
   logic [4:0]  vd_q;
   logic        scalar_en_q;
   logic [31:0] scalar_q;

   // Read-stage element index; counts up to vl and stops there.
   logic [5:0]  idx;
   logic [5:0]  idx_nxt;

   // Execute stage: the element whose read data is on rd_data_* this cycle.
   logic        ex_vld;
   logic [4:0]  ex_idx;

   logic        accept;
   logic [5:0]  vl_sat;
   logic        last_wr;

   assign accept  = issue_valid & issue_ready;
   assign vl_sat  = (issue_vl > 6'd32) ? 6'd32 : issue_vl;
   assign idx_nxt = idx + 6'd1;

   // In DRAIN the last write is the one with nothing left behind it in execute.
   assign last_wr = (state == DRAIN) && wr_en && !ex_vld;

   //------------------------------------------------------------------
   // Control FSM, index counter and captured instruction fields
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         sel_q       <= '0;
         vl_q        <= '0;
         vs1_q       <= '0;
         vs2_q       <= '0;
         vd_q        <= '0;
         scalar_en_q <= 1'b0;
         scalar_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  sel_q       <= issue_alu_sel;
                  vl_q        <= vl_sat;
                  vs1_q       <= issue_vs1;
                  vs2_q       <= issue_vs2;
                  vd_q        <= issue_vd;
                  scalar_en_q <= issue_scalar_en;
                  scalar_q    <= issue_scalar;
                  idx         <= '0;
                  // An empty vector has nothing to read: go straight to the completion state.
                  state       <= (vl_sat == 6'd0) ? DRAIN : RUN;
               end
            end
            RUN: begin
               idx <= idx_nxt;
               if (idx_nxt == vl_q) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // done is high for exactly this one cycle; leave on its edge.
               if (done) begin
                  state <= IDLE;
                  idx   <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   //------------------------------------------------------------------
   // Execute and write-back pipeline
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_vld  <= 1'b0;
         ex_idx  <= '0;
         wr_en   <= 1'b0;
         wr_idx  <= '0;
         wr_data <= '0;
      end else begin
         ex_vld  <= (state == RUN);
         ex_idx  <= (state == RUN) ? idx[4:0] : 5'd0;
         wr_en   <= ex_vld;
         wr_idx  <= ex_vld ? ex_idx : 5'd0;
         wr_data <= ex_vld ? alu_result : 32'd0;
      end
   end

   //------------------------------------------------------------------
   // Completion pulse
   //------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done <= 1'b0;
      end else begin
         done <= (accept && (vl_sat == 6'd0)) || (last_wr && !done);
      end
   end

   //------------------------------------------------------------------
   // Outputs
   //------------------------------------------------------------------
   assign issue_ready = (state == IDLE);
   assign busy        = (state != IDLE);

   assign rd_en       = (state == RUN);
   assign rd_idx      = rd_en ? idx[4:0] : 5'd0;
   assign rd_vreg_a   = vs1_q;
   assign rd_vreg_b   = vs2_q;

   // Operands are held at zero outside the execute stage so idle read data never reaches the ALU.
   assign alu_srcA    = ex_vld ? rd_data_a : 32'd0;
   assign alu_srcB    = ex_vld ? (scalar_en_q ? scalar_q : rd_data_b) : 32'd0;
   assign alu_sel     = sel_q;

   assign wr_vreg     = vd_q;

endmodule

// File: tb/tb_vec_alu_seq.sv
// Testbench for vec_alu_seq: provides a register file and scalar ALU around the sequencer,
// and compares write traffic, timing and final register contents against a reference model.
module tb_vec_alu_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        issue_valid;
   logic        issue_ready;
   logic [3:0]  issue_alu_sel;
   logic [5:0]  issue_vl;
   logic [4:0]  issue_vs1, issue_vs2, issue_vd;
   logic        issue_scalar_en;
   logic [31:0] issue_scalar;
   logic        rd_en;
   logic [4:0]  rd_vreg_a, rd_vreg_b, rd_idx;
   logic [31:0] rd_data_a, rd_data_b;
   logic [31:0] alu_srcA, alu_srcB;
   logic [3:0]  alu_sel;
   logic [31:0] alu_result;
   logic        wr_en;
   logic [4:0]  wr_vreg, wr_idx;
   logic [31:0] wr_data;
   logic        busy, done;

   vec_alu_seq dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_alu_sel(issue_alu_sel), .issue_vl(issue_vl),
      .issue_vs1(issue_vs1), .issue_vs2(issue_vs2), .issue_vd(issue_vd),
      .issue_scalar_en(issue_scalar_en), .issue_scalar(issue_scalar),
      .rd_en(rd_en), .rd_vreg_a(rd_vreg_a), .rd_vreg_b(rd_vreg_b), .rd_idx(rd_idx),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_sel(alu_sel), .alu_result(alu_result),
      .wr_en(wr_en), .wr_vreg(wr_vreg), .wr_idx(wr_idx), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Scalar ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, anything else NOT A.
   function automatic logic [31:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return ~a;
      endcase
   endfunction

   always_comb alu_result = alu_f(alu_sel, alu_srcA, alu_srcB);

   always @(posedge clk) cyc <= cyc + 1;

   // Register file: read data valid the cycle after rd_en, garbage otherwise.
   logic [31:0] rf   [32][32];
   logic [31:0] snap [32][32];
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_a <= rf[rd_vreg_a][rd_idx];
         rd_data_b <= rf[rd_vreg_b][rd_idx];
      end else begin
         rd_data_a <= $urandom;
         rd_data_b <= $urandom;
      end
      if (wr_en === 1'b1) rf[wr_vreg][wr_idx] = wr_data;
   end

   // Monitor, sampled mid-cycle.
   typedef struct { int c; int idx; int vreg; logic [31:0] d; } wr_t;
   wr_t wq[$];
   int  dq[$];
   int  rq_c[$];
   int  rq_i[$];
   int  proto_err = 0;
   always @(negedge clk) begin
      if (wr_en === 1'b1) wq.push_back('{cyc, int'(wr_idx), int'(wr_vreg), wr_data});
      if (done === 1'b1) dq.push_back(cyc);
      if (rd_en === 1'b1) begin
         rq_c.push_back(cyc);
         rq_i.push_back(int'(rd_idx));
      end
      if (rst_n === 1'b1) begin
         if (issue_ready === busy || (rd_en && !busy) || (done && !busy)) proto_err++;
      end
   end

   task automatic clr();
      wq.delete(); dq.delete(); rq_c.delete(); rq_i.delete();
   endtask

   // Offers one instruction, returns the cycle in which the handshake completes.
   task automatic issue(input int vl, input logic [3:0] sel, input logic [4:0] v1, input logic [4:0] v2,
                        input logic [4:0] vd, input logic sen, input logic [31:0] sc, output int a);
      int n;
      @(posedge clk); #1;
      issue_valid = 1'b1; issue_vl = 6'(vl); issue_alu_sel = sel;
      issue_vs1 = v1; issue_vs2 = v2; issue_vd = vd;
      issue_scalar_en = sen; issue_scalar = sc;
      n = 0;
      do begin @(negedge clk); n++; end while (issue_ready !== 1'b1 && n < 100);
      a = cyc;
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL issue_timeout ready=%b want=1", issue_ready);
      end
      @(posedge clk); #1;
      // Scramble the bus: the sequencer must be using its captured copy.
      issue_valid = 1'b0; issue_vl = 6'($urandom); issue_alu_sel = 4'($urandom);
      issue_vs1 = 5'($urandom); issue_vs2 = 5'($urandom); issue_vd = 5'($urandom);
      issue_scalar_en = 1'($urandom); issue_scalar = $urandom;
   endtask

   task automatic wait_done(output int d);
      int n;
      n = 0;
      while (dq.size() == 0 && n < 200) begin @(negedge clk); #1; n++; end
      if (dq.size() == 0) begin
         total++; bad++;
         d = -1;
         $display("FAIL done_timeout got=none want=pulse");
      end else begin
         d = dq[0];
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; issue_valid = 1'b1; issue_vl = 6'd4; issue_alu_sel = 4'd0;
      issue_vs1 = 5'd1; issue_vs2 = 5'd2; issue_vd = 5'd3; issue_scalar_en = 1'b0; issue_scalar = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", issue_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
      total++; if ({done, rd_en, wr_en} !== 3'b000) begin bad++; $display("FAIL rst_strobes got=%b want=000", {done, rd_en, wr_en}); end
      total++; if ({rd_idx, rd_vreg_a, rd_vreg_b, wr_vreg, wr_idx} !== 25'd0) begin bad++;
         $display("FAIL rst_addr got=%h want=0", {rd_idx, rd_vreg_a, rd_vreg_b, wr_vreg, wr_idx}); end
      total++; if (wr_data !== 32'd0) begin bad++; $display("FAIL rst_wr_data got=%h want=0", wr_data); end
      @(posedge clk); #1;
      issue_valid = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_priority busy got=%b want=0", busy); end
   endtask

   task automatic test_add();
      logic [31:0] exp4 [4] = '{32'd11, 32'd22, 32'd33, 32'd44};
      int a, d;
      for (int i = 0; i < 4; i++) begin rf[1][i] = 32'(i + 1); rf[2][i] = 32'(10 * (i + 1)); end
      clr();
      issue(4, 4'd0, 5'd1, 5'd2, 5'd5, 1'b0, 32'd0, a);
      wait_done(d);
      total++; if (wq.size() != 4) begin bad++; $display("FAIL add_count got=%0d want=4", wq.size()); end
      for (int i = 0; i < wq.size() && i < 4; i++) begin
         total++;
         if (wq[i].idx != i || wq[i].d !== exp4[i] || wq[i].c != a + 3 + i || wq[i].vreg != 5) begin bad++;
            $display("FAIL add_wr%0d got idx=%0d d=%0d c=%0d vreg=%0d want idx=%0d d=%0d c=%0d vreg=5",
                     i, wq[i].idx, wq[i].d, wq[i].c, wq[i].vreg, i, exp4[i], a + 3 + i); end
      end
      total++; if (d != a + 7) begin bad++; $display("FAIL add_done got=%0d want=%0d", d, a + 7); end
      total++; if (rq_c.size() != 4 || rq_c[0] != a + 1) begin bad++;
         $display("FAIL add_reads got=%0d want=4 starting %0d", rq_c.size(), a + 1); end
      @(negedge clk);
      total++; if (issue_ready !== 1'b1 || dq.size() != 1) begin bad++;
         $display("FAIL add_ready_after got=%b pulses=%0d want=1 pulses=1", issue_ready, dq.size()); end
   endtask

   task automatic test_scalar_sub();
      logic [31:0] exp3 [3] = '{32'd3, 32'd0, 32'hFFFF_FFFB};
      int a, d;
      rf[6][0] = 32'd8; rf[6][1] = 32'd5; rf[6][2] = 32'd0;
      for (int i = 0; i < 3; i++) rf[7][i] = $urandom;
      clr();
      issue(3, 4'd1, 5'd6, 5'd7, 5'd9, 1'b1, 32'd5, a);
      wait_done(d);
      total++; if (wq.size() != 3) begin bad++; $display("FAIL sub_count got=%0d want=3", wq.size()); end
      for (int i = 0; i < wq.size() && i < 3; i++) begin
         total++;
         if (wq[i].idx != i || wq[i].d !== exp3[i] || wq[i].c != a + 3 + i) begin bad++;
            $display("FAIL sub_wr%0d got idx=%0d d=%h c=%0d want idx=%0d d=%h c=%0d",
                     i, wq[i].idx, wq[i].d, wq[i].c, i, exp3[i], a + 3 + i); end
      end
      total++; if (d != a + 6) begin bad++; $display("FAIL sub_done got=%0d want=%0d", d, a + 6); end
   endtask

   task automatic test_vl0();
      int a, d;
      clr();
      issue(0, 4'd0, 5'd1, 5'd2, 5'd4, 1'b0, 32'd0, a);
      wait_done(d);
      total++; if (d != a + 1) begin bad++; $display("FAIL vl0_done got=%0d want=%0d", d, a + 1); end
      @(negedge clk);
      total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL vl0_ready got=%b want=1", issue_ready); end
      repeat (3) @(negedge clk);
      total++; if (rq_c.size() != 0 || wq.size() != 0 || dq.size() != 1) begin bad++;
         $display("FAIL vl0_traffic got rd=%0d wr=%0d done=%0d want 0 0 1", rq_c.size(), wq.size(), dq.size()); end
   endtask

   task automatic test_saturate();
      int a, d;
      logic [31:0] e;
      snap = rf;
      clr();
      issue(40, 4'd3, 5'd10, 5'd11, 5'd12, 1'b0, 32'd0, a);
      wait_done(d);
      total++; if (wq.size() != 32) begin bad++; $display("FAIL sat_count got=%0d want=32", wq.size()); end
      for (int i = 0; i < wq.size() && i < 32; i++) begin
         e = snap[10][i] | snap[11][i];
         total++;
         if (wq[i].idx != i || wq[i].d !== e || wq[i].c != a + 3 + i) begin bad++;
            $display("FAIL sat_wr%0d got idx=%0d d=%h c=%0d want idx=%0d d=%h c=%0d",
                     i, wq[i].idx, wq[i].d, wq[i].c, i, e, a + 3 + i); end
      end
      total++; if (d != a + 35) begin bad++; $display("FAIL sat_done got=%0d want=%0d", d, a + 35); end
   endtask

   task automatic test_inplace_xor();
      int a, d;
      rf[3][0] = 32'h12; rf[3][1] = 32'h34; rf[4][0] = 32'hFF; rf[4][1] = 32'hFF;
      clr();
      issue(2, 4'd4, 5'd3, 5'd4, 5'd3, 1'b0, 32'd0, a);
      wait_done(d);
      total++; if (rf[3][0] !== 32'hED || rf[3][1] !== 32'hCB) begin bad++;
         $display("FAIL inplace_rf got=%h,%h want=ed,cb", rf[3][0], rf[3][1]); end
      total++; if (wq.size() != 2 || d != a + 5) begin bad++;
         $display("FAIL inplace_timing got wr=%0d done=%0d want wr=2 done=%0d", wq.size(), d, a + 5); end
   endtask

   task automatic test_reset_abort();
      int a, n;
      logic [31:0] orig [8];
      for (int i = 0; i < 8; i++) begin rf[13][i] = $urandom; rf[14][i] = $urandom; rf[15][i] = $urandom; orig[i] = rf[15][i]; end
      clr();
      issue(8, 4'd0, 5'd13, 5'd14, 5'd15, 1'b0, 32'd0, a);
      n = 0;
      while (wq.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
      total++; if (wq.size() != 2) begin bad++; $display("FAIL abort_setup got=%0d want=2", wq.size()); end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      total++; if (wq.size() != 2 || dq.size() != 0) begin bad++;
         $display("FAIL abort_traffic got wr=%0d done=%0d want wr=2 done=0", wq.size(), dq.size()); end
      total++; if (issue_ready !== 1'b1 || busy !== 1'b0) begin bad++;
         $display("FAIL abort_ready got=%b busy=%b want=1 busy=0", issue_ready, busy); end
      total++; if (rf[15][0] !== rf[13][0] + rf[14][0] || rf[15][1] !== rf[13][1] + rf[14][1]) begin bad++;
         $display("FAIL abort_kept got=%h want=%h", rf[15][0], rf[13][0] + rf[14][0]); end
      for (int i = 2; i < 8; i++) begin
         total++; if (rf[15][i] !== orig[i]) begin bad++; $display("FAIL abort_untouched%0d got=%h want=%h", i, rf[15][i], orig[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int a, d, prev_d, vl, eff;
      logic [3:0] sel;
      logic [4:0] v1, v2, vd;
      logic sen;
      logic [31:0] sc, e;
      prev_d = -1;
      for (int k = 0; k < 10; k++) begin
         vl = $urandom_range(0, 40); sel = 4'($urandom_range(0, 7));
         v1 = 5'($urandom); v2 = 5'($urandom);
         vd = ($urandom_range(0, 2) == 0) ? v1 : 5'($urandom);
         sen = 1'($urandom); sc = $urandom;
         eff = (vl > 32) ? 32 : vl;
         snap = rf;
         clr();
         issue(vl, sel, v1, v2, vd, sen, sc, a);
         if (prev_d >= 0) begin
            total++; if (a != prev_d + 1) begin bad++; $display("FAIL b2b_accept%0d got=%0d want=%0d", k, a, prev_d + 1); end
         end
         wait_done(d);
         total++; if (wq.size() != eff || rq_c.size() != eff) begin bad++;
            $display("FAIL b2b_count%0d got wr=%0d rd=%0d want=%0d", k, wq.size(), rq_c.size(), eff); end
         for (int i = 0; i < wq.size() && i < eff; i++) begin
            e = alu_f(sel, snap[v1][i], sen ? sc : snap[v2][i]);
            total++;
            if (wq[i].idx != i || wq[i].d !== e || wq[i].c != a + 3 + i || wq[i].vreg != int'(vd)) begin bad++;
               $display("FAIL b2b_wr%0d_%0d got idx=%0d d=%h c=%0d vreg=%0d want idx=%0d d=%h c=%0d vreg=%0d",
                        k, i, wq[i].idx, wq[i].d, wq[i].c, wq[i].vreg, i, e, a + 3 + i, vd); end
         end
         total++; if (d != ((eff == 0) ? a + 1 : a + eff + 3)) begin bad++;
            $display("FAIL b2b_done%0d got=%0d want=%0d", k, d, (eff == 0) ? a + 1 : a + eff + 3); end
         prev_d = d;
      end
      @(negedge clk);
      total++; if (proto_err != 0) begin bad++; $display("FAIL protocol got=%0d want=0", proto_err); end
   endtask

   initial begin
      for (int r = 0; r < 32; r++)
         for (int e = 0; e < 32; e++)
            rf[r][e] = $urandom;
      test_reset();
      test_add();
      test_scalar_sub();
      test_vl0();
      test_saturate();
      test_inplace_xor();
      test_reset_abort();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
